led_pulse_stretch: RTL and testbench
====================================

Name: led_pulse_stretch

Overview:
Output-side counterpart of the key one-shot: converts single-cycle event pulses into human-visible LED blinks of fixed length.
- One independent channel per LED bit.
- Every channel guarantees a minimum dark gap, so back-to-back events show as separate blinks.
- Sits between control logic (delay/pause/reset strobes, pulse sources) and the board LED pins.

Parameters:
- CHANNELS, 4: number of independent pulse/LED channels.
- TICK_CYCLES, 50000: clk cycles per timing tick (1 ms at 50 MHz); must be >= 2.
- ON_TICKS, 100: LED-on length in ticks; must be >= 1.
- GAP_TICKS, 50: forced LED-off length after each blink, in ticks; 0 means no gap.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-low reset.
- pulse_in  in  CHANNELS  one-cycle event strobes, one per channel.
- led_out  out  CHANNELS  stretched LED drive, active-high, registered.
- busy  out  CHANNELS  channel not IDLE (ON or GAP), registered.
- overrun  out  CHANNELS  one-cycle flag: event dropped, registered.

Behaviour:
Reset:
- When reset==0 at a clk edge: led_out=0, busy=0, overrun=0, all channels IDLE, pending=0, prescaler=0.
- Applies at any point, including mid-blink.

Prescaler:
- Shared, free-running, 0..TICK_CYCLES-1.
- tick is high in the cycle where prescaler==TICK_CYCLES-1, then the prescaler wraps to 0.

Per-channel FSM (IDLE, ON, GAP), 4-bit... rather: down-counter cnt of width clog2(max(ON_TICKS,GAP_TICKS)+1), plus one-deep pending flag:
- IDLE + pulse_in: -> ON, cnt=ON_TICKS. led_out rises in the next cycle (latency 1).
- ON + tick: if cnt>1, decrement. If cnt==1: -> GAP with cnt=GAP_TICKS, or directly -> IDLE/ON when GAP_TICKS==0.
- GAP + tick: if cnt>1, decrement. If cnt==1: -> ON with cnt=ON_TICKS and pending cleared if pending==1; otherwise -> IDLE.
- A tick in the cycle the pulse is accepted from IDLE is not counted.
  - ON duration is (ON_TICKS-1)*TICK_CYCLES+1 .. ON_TICKS*TICK_CYCLES cycles.
  - GAP duration is exactly GAP_TICKS*TICK_CYCLES cycles.
- led_out = (state==ON); busy = (state!=IDLE). Both are registered from the next state.

Retrigger and overrun:
- pulse_in while ON or GAP sets pending. It never extends the current blink.
- pulse_in while pending==1 is dropped; overrun is high for the next cycle only.
- Same cycle as pending is consumed (GAP->ON, or ON->ON when GAP_TICKS==0): the new pulse re-sets pending. No overrun.
- Channels are fully independent; simultaneous pulses on several channels are all accepted.

Decomposition:
- Shared package (or include file) holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ON=2'd1, ST_GAP=2'd2;
  - the clog2 helper function.
- Sub-module led_stretch_chan: one channel FSM, counter, pending and overrun logic; inputs tick and pulse.
- Top module:
  - owns the prescaler;
  - generate-loops CHANNELS instances of led_stretch_chan.

Test Plan:
All tests use TICK_CYCLES=4, ON_TICKS=3, GAP_TICKS=2. Cycle 0 is the first cycle after reset deasserts; prescaler==0 at cycle 0.
- Single blink: pulse_in[0] at cycle 0 -> led_out[0] high cycles 1-11, busy[0] high cycles 1-19, idle from cycle 20; other channels stay 0.
- Queued event: pulse_in[0] at cycles 0 and 5 -> first blink as above, then GAP cycles 12-19, second blink led_out high cycles 20-31; overrun never set.
- Overrun: pulse_in[1] at cycles 0, 4, 6 -> pulse at 6 dropped; overrun[1] high in cycle 7 only; exactly two blinks observed.
- Pending consumed and re-set same cycle: pulse_in[2] at cycles 0, 2, 19 -> blinks start at cycles 1, 20 and 40; no overrun.
- GAP_TICKS=0 variant: pulses at cycles 0 and 2 -> led_out high cycles 1-23 continuously (two back-to-back ON periods), busy drops at cycle 24.
- Reset mid-blink: pulse_in[3] at cycle 0, reset low at cycle 5 -> all outputs 0 from cycle 6; pending cleared; no blink after reset releases without a new pulse.

Source files
------------

// File: rtl/led_pulse_stretch_pkg.sv
// Shared definitions for the LED pulse stretcher: channel state encoding and a width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pulse_stretch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Bits needed to hold 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: IDLE/ON/GAP sequencer with tick down-counter, one-deep pending event and overrun flag.
// Latency: pulse accepted from IDLE shows on led one cycle later; all outputs registered.
// Backpressure: none; one extra event is queued while busy, further events are dropped and flagged.
module led_stretch_chan
  import led_pulse_stretch_pkg::*;
#(
  parameter int ON_TICKS  = 100,
  parameter int GAP_TICKS = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pulse,
  output logic led,
  output logic busy,
  output logic overrun
);

  localparam int CW = clog2(((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) + 1);
  localparam logic [CW-1:0] ON_CNT  = CW'(ON_TICKS);
  localparam logic [CW-1:0] GAP_CNT = CW'(GAP_TICKS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          led_q, busy_q;
  logic          end_busy;

  // Next-state: the busy period ends on the last tick of GAP, or of ON when there is no gap;
  // at that point a queued (or simultaneous) event restarts ON straight away.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovr_d    = 1'b0;
    end_busy = tick && (cnt_q == CNT_ONE) &&
               ((state_q == ST_GAP) || ((state_q == ST_ON) && (GAP_TICKS == 0)));
    if (state_q == ST_IDLE) begin
      pend_d = 1'b0;
      if (pulse) begin
        state_d = ST_ON;
        cnt_d   = ON_CNT;
      end
    end else if ((state_q != ST_ON) && (state_q != ST_GAP)) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else if (end_busy) begin
      if (pend_q || pulse) begin
        state_d = ST_ON;
        cnt_d   = ON_CNT;
        pend_d  = pend_q && pulse;
      end else begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    end else begin
      if (tick) begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Only ON with a non-zero gap can get here with cnt==1.
          state_d = ST_GAP;
          cnt_d   = GAP_CNT;
        end
      end
      if (pulse) begin
        if (pend_q) begin
          ovr_d = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs, taken from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      led_q   <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/led_pulse_stretch.sv
// Stretches one-cycle event strobes into fixed-length LED blinks with a forced dark gap, per channel.
// Latency: led rises one cycle after an accepted strobe; all outputs registered.
// Backpressure: none; each channel queues one event while busy and flags any further one as overrun.
module led_pulse_stretch
  import led_pulse_stretch_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int TICK_CYCLES = 50000,
  parameter int ON_TICKS    = 100,
  parameter int GAP_TICKS   = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pulse_in,
  output logic [CHANNELS-1:0] led_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overrun
);

  localparam int PW = clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // Free-running prescaler shared by all channels; tick marks its last count.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : (pre_q + PRE_ONE);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    led_stretch_chan #(
      .ON_TICKS  (ON_TICKS),
      .GAP_TICKS (GAP_TICKS)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .pulse   (pulse_in[g]),
      .led     (led_out[g]),
      .busy    (busy[g]),
      .overrun (overrun[g])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Bench for led_pulse_stretch: directed scenarios then random strobes, two builds (gap 2 and gap 0).
// Expected outputs come from a time-interval reference model and are queued per cycle.
// A separate monitor pops and compares on the falling edge.
module tb_led_pulse_stretch;

  localparam int CH  = 4;
  localparam int TC  = 4;
  localparam int ONT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] pulse_in = '0;
  logic [CH-1:0] led_a, busy_a, ovr_a;
  logic [CH-1:0] led_b, busy_b, ovr_b;

  always #5 clk = ~clk;

  led_pulse_stretch #(.CHANNELS(CH), .TICK_CYCLES(TC), .ON_TICKS(ONT), .GAP_TICKS(2)) dut_a (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .led_out(led_a), .busy(busy_a), .overrun(ovr_a));

  led_pulse_stretch #(.CHANNELS(CH), .TICK_CYCLES(TC), .ON_TICKS(ONT), .GAP_TICKS(0)) dut_b (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .led_out(led_b), .busy(busy_b), .overrun(ovr_b));

  typedef struct packed {
    int         stamp;
    logic [7:0] led;
    logic [7:0] busy;
    logic [7:0] ovr;
  } exp_t;

  exp_t q[$];
  int   gcyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Reference model: each blink is an interval of absolute cycles since reset release.
  int mc;
  bit act  [2][CH];
  bit pend [2][CH];
  int ons  [2][CH];
  int one  [2][CH];
  int ge   [2][CH];

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Cycle of the n-th tick strictly after cycle c (ticks at c % TC == TC-1).
  function automatic int nth_tick(input int c, input int n);
    int t;
    if (n == 0) return c;
    t = (c / TC) * TC + TC - 1;
    if (t <= c) t = t + TC;
    return t + (n - 1) * TC;
  endfunction

  task automatic start_blink(input int k, input int ch, input int c);
    act[k][ch] = 1'b1;
    ons[k][ch] = c + 1;
    one[k][ch] = nth_tick(c, ONT);
    ge[k][ch]  = nth_tick(one[k][ch], gap_of(k));
  endtask

  task automatic step(input logic r, input logic [CH-1:0] p);
    exp_t e;
    int   c;
    int   n;
    bit   o;
    bit   np;
    @(posedge clk);
    #1;
    reset    = r;
    pulse_in = p;
    e        = '0;
    e.stamp  = gcyc + 1;
    c        = mc;
    n        = c + 1;
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        o = 1'b0;
        if (!r) begin
          act[k][ch]  = 1'b0;
          pend[k][ch] = 1'b0;
        end else if (!act[k][ch] || c > ge[k][ch]) begin
          act[k][ch]  = 1'b0;
          pend[k][ch] = 1'b0;
          if (p[ch]) start_blink(k, ch, c);
        end else if (c == ge[k][ch]) begin
          if (pend[k][ch] || p[ch]) begin
            np = pend[k][ch] && p[ch];
            start_blink(k, ch, c);
            pend[k][ch] = np;
          end
        end else if (p[ch]) begin
          if (pend[k][ch]) o = 1'b1;
          else pend[k][ch] = 1'b1;
        end
        if (r && act[k][ch]) begin
          e.led[k*CH+ch]  = (n >= ons[k][ch]) && (n <= one[k][ch]);
          e.busy[k*CH+ch] = (n >= ons[k][ch]) && (n <= ge[k][ch]);
        end
        e.ovr[k*CH+ch] = o;
      end
    end
    mc = r ? (c + 1) : 0;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int k, input logic [CH-1:0] got, input logic [CH-1:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s gap%0d cyc=%0d got=%b want=%b", name, gap_of(k), gcyc, got, want);
    end
  endtask

  // Monitor: compare the DUT outputs of this cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].stamp == gcyc) begin
        e = q.pop_front();
        chk("led",     0, led_a,  e.led[3:0]);
        chk("busy",    0, busy_a, e.busy[3:0]);
        chk("overrun", 0, ovr_a,  e.ovr[3:0]);
        chk("led",     1, led_b,  e.led[7:4]);
        chk("busy",    1, busy_b, e.busy[7:4]);
        chk("overrun", 1, ovr_b,  e.ovr[7:4]);
      end
    end
  end

  // Directed scenario: pulses on one channel at up to three cycles, optional mid-run reset.
  task automatic scn(input int ch, input int c0, input int c1, input int c2, input int rst_at, input int len);
    logic [CH-1:0] p;
    step(1'b0, '0);
    step(1'b0, '0);
    for (int c = 0; c < len; c++) begin
      p = '0;
      if (c == c0 || c == c1 || c == c2) p[ch] = 1'b1;
      step((c == rst_at) ? 1'b0 : 1'b1, p);
    end
  endtask

  initial begin
    logic [CH-1:0] p;
    logic          r;
    mc = 0;
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < CH; ch++) begin
        act[k][ch] = 1'b0; pend[k][ch] = 1'b0;
        ons[k][ch] = 0; one[k][ch] = 0; ge[k][ch] = 0;
      end
    scn(0, 0, -1, -1, -1, 26);
    scn(0, 0, 5, -1, -1, 44);
    scn(1, 0, 4, 6, -1, 44);
    scn(2, 0, 2, 19, -1, 64);
    scn(0, 0, 2, -1, -1, 30);
    scn(3, 0, -1, -1, 5, 40);
    step(1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < CH; ch++) p[ch] = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) != 0);
      step(r, p);
    end
    step(1'b1, '0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
